// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding imem
// reads and hands fetched instructions to decode over valid/ready.
module fetch_sequencer #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned           PC_INCR      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_pc,
    input  logic                  enable_pd,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] pc_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] INCR       = ADDR_WIDTH'(PC_INCR);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(INCR - 1'b1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic                  valid_q, valid_d;
    logic                  squash_q, squash_d;

    logic [ADDR_WIDTH-1:0] tgt_al;
    logic [ADDR_WIDTH-1:0] fetch_pc;

    assign tgt_al = branch_target & ALIGN_MASK;
    // A redirect in the same cycle wins over the held PC.
    assign fetch_pc = branch_taken ? tgt_al : pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        squash_d = squash_q;

        unique case (state_q)
            S_IDLE: begin
                pc_d = fetch_pc;
                if (enable_pd) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (imem_ack) begin
                    if (squash_q || branch_taken) begin
                        squash_d = 1'b0;
                        pc_d     = fetch_pc;
                        if (enable_pd) begin
                            addr_d = fetch_pc;
                        end else begin
                            req_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        pc_d    = pc_q + INCR;
                        state_d = S_HOLD;
                    end
                end else if (branch_taken) begin
                    // Request in flight cannot be aborted; drop its data later.
                    pc_d     = tgt_al;
                    squash_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (branch_taken || instr_ready) begin
                    valid_d = 1'b0;
                    pc_d    = fetch_pc;
                    if (enable_pd) begin
                        req_d   = 1'b1;
                        addr_d  = fetch_pc;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clr_pc) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_VECTOR;
            req_q    <= 1'b0;
            addr_q   <= '0;
            instr_q  <= '0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            squash_q <= squash_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand sequences and a
// randomized run checked against an instruction-stream reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr_pc;
    logic        enable_pd;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .clr_pc       (clr_pc),
        .enable_pd    (enable_pd),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_out       (pc_out)
    );

    typedef struct {
        logic        rst, clr, en, br;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr, e_ipc, e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, clr, en, br, input logic [31:0] tgt,
        input logic ack, input logic [31:0] rdata, input logic rdy,
        input logic e_req, input logic [31:0] e_addr,
        input logic e_valid, input logic [31:0] e_instr,
        input logic [31:0] e_ipc, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.clr = clr; v.en = en; v.br = br; v.tgt = tgt;
        v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_pc = e_pc;
        return v;
    endfunction

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, clr, en, br,
                         input logic [31:0] tgt, input logic ack,
                         input logic [31:0] rd, input logic rdy);
        reset = rst; clr_pc = clr; enable_pd = en; branch_taken = br;
        branch_target = tgt; imem_ack = ack; imem_rdata = rd;
        instr_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].clr, tbl[i].en, tbl[i].br,
                  tbl[i].tgt, tbl[i].ack, tbl[i].rdata, tbl[i].rdy);
            tick();
            chk($sformatf("r%0d.req", i), imem_req, tbl[i].e_req);
            chk($sformatf("r%0d.addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("r%0d.valid", i), instr_valid, tbl[i].e_valid);
            chk($sformatf("r%0d.instr", i), instr, tbl[i].e_instr);
            chk($sformatf("r%0d.ipc", i), instr_pc, tbl[i].e_ipc);
            chk($sformatf("r%0d.pc", i), pc_out, tbl[i].e_pc);
        end
    endtask

    task automatic hand_seq();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
        chk("h.first_req", imem_req, 1);
        drive(0, 0, 1, 0, 0, 1, 32'h11, 0); tick();
        chk("h.first_valid", instr_valid, 1);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
            chk($sformatf("h.stall%0d.req", k), imem_req, 0);
            chk($sformatf("h.stall%0d.valid", k), instr_valid, 1);
            chk($sformatf("h.stall%0d.instr", k), instr, 32'h11);
        end
        drive(0, 0, 1, 0, 0, 0, 0, 1); tick();
        chk("h.accept.req", imem_req, 1);
        chk("h.accept.addr", imem_addr, 32'h4);
        chk("h.accept.valid", instr_valid, 0);
        drive(0, 0, 1, 0, 0, 1, 32'h22, 0); tick();
        chk("h.second.ipc", instr_pc, 32'h4);
        drive(0, 0, 1, 0, 0, 0, 0, 1); tick();
        chk("h.req8.addr", imem_addr, 32'h8);
        chk("h.req8.req", imem_req, 1);
        drive(0, 1, 1, 0, 0, 0, 0, 0); tick();
        chk("h.clr.req", imem_req, 0);
        chk("h.clr.pc", pc_out, 0);
        chk("h.clr.valid", instr_valid, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
        chk("h.refetch.req", imem_req, 1);
        chk("h.refetch.addr", imem_addr, 0);
    endtask

    task automatic random_run(input int cycles);
        logic [31:0] exp_pc;
        int          n_acc;
        logic        en, br, clr, ack, rdy;
        logic [31:0] tgt, rd;
        logic        p_clr, p_en, p_br, p_ack, p_rdy, p_req, p_valid;
        logic [31:0] p_addr, p_instr, p_ipc;
        bit          have_prev;
        exp_pc = 32'h0;
        n_acc = 0;
        en = 1'b1;
        have_prev = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int c = 0; c < cycles; c++) begin
            if (have_prev) begin
                if (p_clr) begin
                    chk("rnd.clr.req", imem_req, 0);
                    chk("rnd.clr.valid", instr_valid, 0);
                    chk("rnd.clr.pc", pc_out, 0);
                end else begin
                    if (p_req && !p_ack) begin
                        chk("rnd.req_held", imem_req, 1);
                        chk("rnd.addr_stable", imem_addr, p_addr);
                    end
                    if (p_valid && !p_rdy && !p_br) begin
                        chk("rnd.valid_held", instr_valid, 1);
                        chk("rnd.instr_stable", instr, p_instr);
                        chk("rnd.ipc_stable", instr_pc, p_ipc);
                    end
                    if (!p_en && !p_req)
                        chk("rnd.no_req_disabled", imem_req, 0);
                end
                if (imem_req && instr_valid)
                    chk("rnd.req_and_valid", 1, 0);
            end
            if ($urandom_range(99) < 5) en = ~en;
            clr = ($urandom_range(99) < 1);
            br  = ($urandom_range(99) < 5);
            tgt = $urandom;
            rdy = ($urandom_range(99) < 60);
            if (imem_req) begin
                ack = ($urandom_range(99) < 40);
                rd  = mem_f(imem_addr);
            end else begin
                ack = ($urandom_range(99) < 5);
                rd  = $urandom;
            end
            if (clr) begin
                exp_pc = 32'h0;
            end else begin
                if (instr_valid && rdy && !br) begin
                    chk("rnd.accept_pc", instr_pc, exp_pc);
                    chk("rnd.accept_data", instr, mem_f(instr_pc));
                    exp_pc = instr_pc + 32'd4;
                    n_acc++;
                end
                if (br) exp_pc = tgt & ~32'h3;
            end
            p_clr = clr; p_en = en; p_br = br; p_ack = ack; p_rdy = rdy;
            p_req = imem_req; p_valid = instr_valid; p_addr = imem_addr;
            p_instr = instr; p_ipc = instr_pc;
            have_prev = 1;
            drive(0, clr, en, br, tgt, ack, rd, rdy);
            tick();
        end
        chk("rnd.progress", (n_acc > 100) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        //        rst clr en br tgt          ack rdata        rdy  req addr         v instr        ipc          pc
        tbl.push_back(mk(1,0,0,0,32'h0,        0,32'h0,       0,   0,32'h0,       0,32'h0,       32'h0,       32'h0));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       1,   1,32'h0,       0,32'h0,       32'h0,       32'h0));
        tbl.push_back(mk(0,0,1,0,32'h0,        1,32'h11,      1,   0,32'h0,       1,32'h11,      32'h0,       32'h4));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       1,   1,32'h4,       0,32'h11,      32'h0,       32'h4));
        tbl.push_back(mk(0,0,1,0,32'h0,        1,32'h22,      1,   0,32'h4,       1,32'h22,      32'h4,       32'h8));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       1,   1,32'h8,       0,32'h22,      32'h4,       32'h8));
        tbl.push_back(mk(0,0,1,0,32'h0,        1,32'h33,      0,   0,32'h8,       1,32'h33,      32'h8,       32'hC));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       0,   0,32'h8,       1,32'h33,      32'h8,       32'hC));
        tbl.push_back(mk(0,0,1,0,32'h0,        1,32'hBAD,     0,   0,32'h8,       1,32'h33,      32'h8,       32'hC));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       0,   0,32'h8,       1,32'h33,      32'h8,       32'hC));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       1,   1,32'hC,       0,32'h33,      32'h8,       32'hC));
        tbl.push_back(mk(0,0,1,1,32'h103,      0,32'h0,       0,   1,32'hC,       0,32'h33,      32'h8,       32'h100));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       0,   1,32'hC,       0,32'h33,      32'h8,       32'h100));
        tbl.push_back(mk(0,0,1,0,32'h0,        1,32'hDEAD,    0,   1,32'h100,     0,32'h33,      32'h8,       32'h100));
        tbl.push_back(mk(0,0,1,0,32'h0,        1,32'h55,      0,   0,32'h100,     1,32'h55,      32'h100,     32'h104));
        tbl.push_back(mk(0,0,1,1,32'h40,       0,32'h0,       1,   1,32'h40,      0,32'h55,      32'h100,     32'h40));
        tbl.push_back(mk(0,0,1,0,32'h0,        1,32'h66,      0,   0,32'h40,      1,32'h66,      32'h40,      32'h44));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       1,   1,32'h44,      0,32'h66,      32'h40,      32'h44));
        tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,       0,   1,32'h44,      0,32'h66,      32'h40,      32'h44));
        tbl.push_back(mk(0,0,0,0,32'h0,        1,32'h77,      0,   0,32'h44,      1,32'h77,      32'h44,      32'h48));
        tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,       1,   0,32'h44,      0,32'h77,      32'h44,      32'h48));
        tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,       0,   0,32'h44,      0,32'h77,      32'h44,      32'h48));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       0,   1,32'h48,      0,32'h77,      32'h44,      32'h48));
        tbl.push_back(mk(0,1,1,0,32'h0,        0,32'h0,       0,   0,32'h0,       0,32'h0,       32'h0,       32'h0));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       0,   1,32'h0,       0,32'h0,       32'h0,       32'h0));
        tbl.push_back(mk(0,0,1,1,32'hFFFFFFFC, 0,32'h0,       0,   1,32'h0,       0,32'h0,       32'h0,       32'hFFFFFFFC));
        tbl.push_back(mk(0,0,1,0,32'h0,        1,32'hAB,      0,   1,32'hFFFFFFFC,0,32'h0,       32'h0,       32'hFFFFFFFC));
        tbl.push_back(mk(0,0,1,0,32'h0,        1,32'h88,      0,   0,32'hFFFFFFFC,1,32'h88,      32'hFFFFFFFC,32'h0));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       1,   1,32'h0,       0,32'h88,      32'hFFFFFFFC,32'h0));
        tbl.push_back(mk(0,0,1,1,32'h204,      1,32'h99,      0,   1,32'h204,     0,32'h88,      32'hFFFFFFFC,32'h204));
        tbl.push_back(mk(0,0,1,0,32'h0,        1,32'h9A,      0,   0,32'h204,     1,32'h9A,      32'h204,     32'h208));
        tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,       1,   0,32'h204,     0,32'h9A,      32'h204,     32'h208));
        tbl.push_back(mk(0,0,0,0,32'h0,        1,32'hEE,      0,   0,32'h204,     0,32'h9A,      32'h204,     32'h208));
        tbl.push_back(mk(0,0,0,1,32'h301,      0,32'h0,       0,   0,32'h204,     0,32'h9A,      32'h204,     32'h300));
        tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,       0,   1,32'h300,     0,32'h9A,      32'h204,     32'h300));

        run_table();
        hand_seq();
        random_run(4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
